// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and frame layout.
package imem_loader_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_HDR  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA = 3'd2;
    localparam logic [STATE_W-1:0] ST_CSUM = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd5;

    localparam int unsigned LOADER_HDR_BYTES = 4;
    localparam int unsigned CSUM_W           = 8;

endpackage

// File: rtl/imem_loader.sv
// Receives a length-prefixed, checksummed byte frame and writes its payload into
// instruction memory from address 0 upward, holding the CPU while loading.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] MEM_BYTES_W = ADDR_W'(MEM_BYTES);
    localparam logic [1:0]        HDR_LAST    = 2'(LOADER_HDR_BYTES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CSUM_W-1:0]  sum_q, sum_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer;
    logic [ADDR_W-1:0]  len_next;
    logic [CSUM_W-1:0]  sum_next;

    always_comb begin
        in_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    end

    assign xfer     = in_valid && in_ready;
    // Header arrives little-endian: byte k lands at bit 8*k.
    assign len_next = len_q | (ADDR_W'(in_data) << {hdr_cnt_q, 3'b000});
    assign sum_next = sum_q + in_data;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_HDR;
                    hdr_cnt_d  = 2'd0;
                    len_d      = '0;
                    byte_cnt_d = '0;
                    sum_d      = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    len_d     = len_next;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == HDR_LAST) begin
                        if (len_next == '0) begin
                            state_d = ST_CSUM;
                        end else if (len_next > MEM_BYTES_W) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = byte_cnt_q;
                    mem_wdata_d = in_data;
                    sum_d       = sum_next;
                    byte_cnt_d  = byte_cnt_q + ADDR_W'(1);
                    if (byte_cnt_q == len_q - ADDR_W'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (sum_next == '0) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= 2'd0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model checked every cycle, plus
// hand-computed literal checks on each directed scenario.
module tb_imem_loader;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame, not loader states.
    logic        m_busy;
    int          m_pos;
    logic [31:0] m_len;
    int          m_sum;
    logic        exp_we, exp_hold, exp_done, exp_err;
    int          exp_addr;
    logic [7:0]  exp_wdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_pos = 0; m_len = 0; m_sum = 0;
            exp_we = 0; exp_addr = 0; exp_wdata = 0;
            exp_hold = 0; exp_done = 0; exp_err = 0;
        end else begin
            exp_we = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_pos = 0; m_len = 0; m_sum = 0;
                    exp_hold = 1; exp_done = 0; exp_err = 0;
                end
            end else if (in_valid) begin
                if (m_pos < 4) begin
                    m_len[8*m_pos +: 8] = in_data;
                    if (m_pos == 3 && m_len > MEM_BYTES) begin
                        m_busy = 0;
                        exp_err = 1;
                    end
                end else if (m_pos - 4 < int'(m_len)) begin
                    exp_we = 1;
                    exp_addr = m_pos - 4;
                    exp_wdata = in_data;
                    m_sum += in_data;
                end else begin
                    m_busy = 0;
                    if ((m_sum + in_data) % 256 == 0) begin
                        exp_done = 1;
                        exp_hold = 0;
                    end else begin
                        exp_err = 1;
                    end
                end
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, m_busy);
            check("mem_we", mem_we, exp_we);
            check("cpu_hold", cpu_hold, exp_hold);
            check("done", done, exp_done);
            check("err", err, exp_err);
            if (exp_we) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    logic [7:0] wr_data[$];
    int         wr_addr[$];
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wr_data.push_back(mem_wdata);
            wr_addr.push_back(mem_addr);
        end
    end

    task automatic clear_log();
        wr_data.delete();
        wr_addr.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int   n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            fails++;
            $display("FAIL send_byte_timeout: got no acceptance, expected acceptance of %0h", b);
        end
        in_valid = 1'b0;
        in_data  = 8'hxx;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i]) send_byte(bytes[i], gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic check_good_log(input string tag);
        check({tag, "_wr_count"}, wr_data.size(), 4);
        if (wr_data.size() == 4) begin
            check({tag, "_wr0"}, {wr_addr[0][23:0], wr_data[0]}, {24'd0, 8'h83});
            check({tag, "_wr1"}, {wr_addr[1][23:0], wr_data[1]}, {24'd1, 8'h20});
            check({tag, "_wr2"}, {wr_addr[2][23:0], wr_data[2]}, {24'd2, 8'h00});
            check({tag, "_wr3"}, {wr_addr[3][23:0], wr_data[3]}, {24'd3, 8'h00});
        end
    endtask

    task automatic check_result(input string tag, input logic d, input logic e, input logic h);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_done"}, done, d);
        check({tag, "_err"}, err, e);
        check({tag, "_hold"}, cpu_hold, h);
        check({tag, "_ready"}, in_ready, 0);
    endtask

    logic [7:0] good_frame[$] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h83, 8'h20, 8'h00, 8'h00, 8'h5D};
    logic [7:0] bad_frame[$]  = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h83, 8'h20, 8'h00, 8'h00, 8'h5C};
    logic [7:0] big_hdr[$]    = '{8'h01, 8'h10, 8'h00, 8'h00};
    logic [7:0] zero_frame[$] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        #2;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Normal load, back-to-back.
        clear_log();
        pulse_start();
        send_frame(good_frame, 0);
        check_result("normal", 1, 0, 0);
        check("model_done", exp_done, 1);
        check_good_log("normal");

        // Bad checksum.
        clear_log();
        pulse_start();
        send_frame(bad_frame, 0);
        check_result("badsum", 0, 1, 1);
        check("model_err", exp_err, 1);
        check_good_log("badsum");

        // Oversize length, then keep offering data that must be refused.
        clear_log();
        pulse_start();
        send_frame(big_hdr, 0);
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        check_result("oversize", 0, 1, 1);
        check("oversize_wr_count", wr_data.size(), 0);

        // Zero length.
        clear_log();
        pulse_start();
        send_frame(zero_frame, 0);
        check_result("zero", 1, 0, 0);
        check("zero_wr_count", wr_data.size(), 0);

        // Normal load with idle gaps on in_valid.
        clear_log();
        pulse_start();
        send_frame(good_frame, 1);
        check_result("gaps", 1, 0, 0);
        check_good_log("gaps");

        // Reset after two payload bytes; outputs drop without waiting for a clock.
        clear_log();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(good_frame[i], 0);
        rst = 1'b1;
        #1;
        check("midrst_ready", in_ready, 0);
        check("midrst_we", mem_we, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wdata", mem_wdata, 0);
        check("midrst_hold", cpu_hold, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        clear_log();
        pulse_start();
        send_frame(good_frame, 0);
        check_result("reload", 1, 0, 0);
        check_good_log("reload");

        // Start pulsed during DATA must be ignored.
        clear_log();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(good_frame[i], 0);
        start = 1'b1;
        send_byte(good_frame[5], 0);
        start = 1'b0;
        for (int i = 6; i < 9; i++) send_byte(good_frame[i], 0);
        check_result("busystart", 1, 0, 0);
        check_good_log("busystart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
